// File: rtl/fb_write_sched.sv
// Per-frame scheduler for the framebuffer GPU write port: clears the freshly
// exposed write buffer after each vsync-driven swap, then hands the port to the rasterizer.
module fb_write_sched #(
  parameter int          ADDR_WIDTH  = 17,
  parameter int          NUM_PIXELS  = 76800,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  raster_valid,
  input  logic [ADDR_WIDTH-1:0] raster_addr,
  input  logic [7:0]            raster_data,
  input  logic                  render_done,
  output logic                  raster_ready,
  output logic                  fb_wea,
  output logic [ADDR_WIDTH-1:0] fb_addra,
  output logic [7:0]            fb_dina,
  output logic                  frame_start,
  output logic                  clear_busy,
  output logic [7:0]            overrun_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, RENDER, WAIT_SWAP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH + 1)'(NUM_PIXELS);

  state_t                state, state_nxt;
  logic                  s1, s2, p;
  logic                  swap;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  wea_nxt, fs_nxt, ovr_inc;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            din_nxt;
  logic                  accept, in_range;

  // Falling edge of the synchronized vsync; same cycle the framebuffer toggles its buffer.
  assign swap         = p & ~s2;
  assign raster_ready = (state == RENDER);
  assign clear_busy   = (state == CLEAR);
  assign accept       = raster_valid & raster_ready;
  assign in_range     = ({1'b0, raster_addr} < PIX_LIMIT);

  // Handshake: a raster write transfers on any clk edge where raster_valid & raster_ready.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wea_nxt     = 1'b0;
    addr_nxt    = fb_addra;
    din_nxt     = fb_dina;
    fs_nxt      = 1'b0;
    ovr_inc     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
      CLEAR: begin
        if (swap) begin
          clr_cnt_nxt = '0;
          ovr_inc     = 1'b1;
        end else begin
          wea_nxt     = 1'b1;
          addr_nxt    = clr_cnt;
          din_nxt     = CLEAR_COLOR;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state_nxt = RENDER;
            fs_nxt    = 1'b1;
          end
        end
      end
      RENDER: begin
        if (accept && in_range) begin
          wea_nxt  = 1'b1;
          addr_nxt = raster_addr;
          din_nxt  = raster_data;
        end
        // A swap that coincides with render_done is an on-time frame, not an overrun.
        if (swap) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          ovr_inc     = ~render_done;
        end else if (render_done) begin
          state_nxt = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (swap) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      p           <= 1'b0;
      clr_cnt     <= '0;
      fb_wea      <= 1'b0;
      fb_addra    <= '0;
      fb_dina     <= 8'h00;
      frame_start <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      state       <= state_nxt;
      s1          <= vsync;
      s2          <= s1;
      p           <= s2;
      clr_cnt     <= clr_cnt_nxt;
      fb_wea      <= wea_nxt;
      fb_addra    <= addr_nxt;
      fb_dina     <= din_nxt;
      frame_start <= fs_nxt;
      if (ovr_inc && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched with a write scoreboard on the fb_* port.
module tb_fb_write_sched;
  localparam int AW = 5;
  localparam int NP = 16;
  localparam int W  = AW + 8;

  logic          clk, rst, vsync, raster_valid, render_done;
  logic [AW-1:0] raster_addr;
  logic [7:0]    raster_data;
  logic          raster_ready, fb_wea, frame_start, clear_busy;
  logic [AW-1:0] fb_addra;
  logic [7:0]    fb_dina, overrun_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  bit           sb_on;
  int           n_tests, n_fail;

  fb_write_sched #(.ADDR_WIDTH(AW), .NUM_PIXELS(NP), .CLEAR_COLOR(8'h00)) dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .raster_valid(raster_valid), .raster_addr(raster_addr), .raster_data(raster_data),
    .render_done(render_done), .raster_ready(raster_ready),
    .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina),
    .frame_start(frame_start), .clear_busy(clear_busy), .overrun_cnt(overrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every fb write seen while enabled must match the head of exp_q.
  task automatic sb_sample();
    if (sb_on && fb_wea === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed write addr %0h data %0h, expected no write", fb_addra, fb_dina);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        n_tests++;
        assert ({fb_addra, fb_dina} === exp_v) else begin
          n_fail++;
          $error("FAIL sb_write: observed addr %0h data %0h expected addr %0h data %0h",
                 fb_addra, fb_dina, exp_v[W-1:8], exp_v[7:0]);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_sample();
    #1;
  endtask

  task automatic push_clear();
    for (int i = 0; i < NP; i++) exp_q.push_back({AW'(i), 8'h00});
  endtask

  task automatic wait_fs(input int bound, input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (frame_start !== 1'b1 && k < bound);
    chk(tag, 32'(frame_start), 32'd1);
  endtask

  task automatic wait_write(input logic [AW-1:0] a, input int bound, input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(fb_wea === 1'b1 && fb_addra === a) && k < bound);
    chk(tag, 32'(fb_wea === 1'b1 && fb_addra === a), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wea"},   32'(fb_wea),       32'd0);
    chk({tag, "_addra"}, 32'(fb_addra),     32'd0);
    chk({tag, "_dina"},  32'(fb_dina),      32'd0);
    chk({tag, "_ready"}, 32'(raster_ready), 32'd0);
    chk({tag, "_fs"},    32'(frame_start),  32'd0);
    chk({tag, "_busy"},  32'(clear_busy),   32'd0);
    chk({tag, "_ovr"},   32'(overrun_cnt),  32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sb_on = 1'b1;
    rst = 1'b1; vsync = 1'b1; raster_valid = 1'b0; raster_addr = '0;
    raster_data = 8'h00; render_done = 1'b0;

    // Reset state, then the power-up clear of 0..NP-1.
    repeat (3) tick();
    check_zero_outputs("reset");
    push_clear();
    rst = 1'b0;
    repeat (4) tick();
    chk("clear_ready_low", 32'(raster_ready), 32'd0);
    chk("clear_busy_high", 32'(clear_busy), 32'd1);
    wait_fs(40, "first_frame_start");
    chk("first_clear_drained", 32'(exp_q.size()), 32'd0);
    chk("ready_with_fs", 32'(raster_ready), 32'd1);

    // Render: in-range write lands one cycle later, out-of-range write is dropped.
    raster_valid = 1'b1; raster_addr = 5'd3; raster_data = 8'hA5;
    exp_q.push_back({5'd3, 8'hA5});
    tick();
    chk("fs_one_pulse", 32'(frame_start), 32'd0);
    chk("render_ready_1", 32'(raster_ready), 32'd1);
    chk("write3_wea", 32'(fb_wea), 32'd1);
    chk("write3_addr", 32'(fb_addra), 32'd3);
    raster_addr = 5'd16; raster_data = 8'hFF;
    tick();
    chk("oob_dropped", 32'(fb_wea), 32'd0);
    chk("render_ready_2", 32'(raster_ready), 32'd1);
    raster_valid = 1'b0;

    // render_done, then an on-time swap.
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    chk("wait_swap_ready", 32'(raster_ready), 32'd0);
    chk("wait_swap_busy", 32'(clear_busy), 32'd0);
    repeat (3) tick();
    chk("wait_swap_no_write", 32'(fb_wea), 32'd0);
    vsync = 1'b0;
    push_clear();
    repeat (3) tick();
    chk("swap_edge3_no_write", 32'(fb_wea), 32'd0);
    chk("swap_edge3_busy", 32'(clear_busy), 32'd1);
    tick();
    chk("swap_edge4_wea", 32'(fb_wea), 32'd1);
    chk("swap_edge4_addr", 32'(fb_addra), 32'd0);
    vsync = 1'b1;
    chk("ontime_no_overrun", 32'(overrun_cnt), 32'd0);
    wait_fs(40, "second_frame_start");
    chk("second_clear_drained", 32'(exp_q.size()), 32'd0);

    // Overruns: swap during RENDER without render_done, then again mid-clear.
    sb_on = 1'b0;
    vsync = 1'b0;
    repeat (3) tick();
    chk("abort_busy", 32'(clear_busy), 32'd1);
    chk("abort_ovr1", 32'(overrun_cnt), 32'd1);
    tick();
    chk("abort_restart_wea", 32'(fb_wea), 32'd1);
    chk("abort_restart_addr", 32'(fb_addra), 32'd0);
    vsync = 1'b1;
    wait_write(5'd5, 20, "reach_addr5");
    vsync = 1'b0;
    wait_write(5'd0, 8, "midclear_restart_addr0");
    chk("midclear_ovr2", 32'(overrun_cnt), 32'd2);
    vsync = 1'b1;
    wait_fs(40, "frame_start_after_overruns");

    // Swap coinciding with render_done: clear again with no overrun.
    vsync = 1'b0;
    tick();
    tick();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    chk("coincide_busy", 32'(clear_busy), 32'd1);
    chk("coincide_ready", 32'(raster_ready), 32'd0);
    chk("coincide_ovr", 32'(overrun_cnt), 32'd2);
    vsync = 1'b1;

    // Saturation: a swap every 8 cycles keeps the clear from ever finishing.
    for (int i = 0; i < 300; i++) begin
      repeat (4) tick();
      vsync = 1'b0;
      repeat (4) tick();
      vsync = 1'b1;
      if (i == 99) chk("ovr_102", 32'(overrun_cnt), 32'd102);
    end
    chk("ovr_saturated", 32'(overrun_cnt), 32'd255);
    wait_fs(60, "frame_start_after_saturation");

    // Asynchronous reset mid-clear at address 7.
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    vsync = 1'b0;
    repeat (4) tick();
    vsync = 1'b1;
    wait_write(5'd7, 30, "reach_addr7");
    #1 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    tick();
    push_clear();
    sb_on = 1'b1;
    // Writes and render_done offered outside RENDER must be ignored.
    raster_valid = 1'b1; raster_addr = 5'd2; raster_data = 8'h77;
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(raster_ready), 32'd0);
    repeat (3) tick();
    chk("clear_rejects_write", 32'(raster_ready), 32'd0);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    raster_valid = 1'b0;
    wait_fs(40, "frame_start_after_reset");
    chk("reset_clear_drained", 32'(exp_q.size()), 32'd0);
    chk("ovr_after_reset", 32'(overrun_cnt), 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
